// File: rtl/fp_mul_booth_seq.sv
// fp_mul_booth_seq: iterative radix-4 Booth significand multiplier for binary32 operands.
// Optional FP_MUL_BOOTH_ZERO_SKIP_EN bypasses the digit loop when either operand is zero/subnormal.
module fp_mul_booth_seq #(
  parameter int MAN_W  = 24,
  parameter int DIGITS = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        fp_X,
  input  logic [31:0]        fp_Y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*MAN_W-1:0] frc_Z_full,
  output logic               sign_Z,
  output logic               busy
);
  localparam int AW = 2*MAN_W + 2;
  localparam int MW = 2*DIGITS + 1;
  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d, a_ext, pp;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   m_q, m_d;
  logic [MAN_W-1:0] a_q, a_d, a_in, b_in;
  logic            sign_q, sign_d, x_sub, y_sub, accept;
  assign x_sub  = fp_X[30:23] == 8'd0;
  assign y_sub  = fp_Y[30:23] == 8'd0;
  assign a_in   = x_sub ? '0 : {1'b1, fp_X[MAN_W-2:0]};
  assign b_in   = y_sub ? '0 : {1'b1, fp_Y[MAN_W-2:0]};
  assign accept = in_valid && in_ready;
  assign a_ext  = {{(AW-MAN_W){1'b0}}, a_q};
  // Booth digit selects 0, +-A or +-2A from the current overlapping multiplier triplet
  always_comb begin
    pp = (m_q[2:0] == 3'b001 || m_q[2:0] == 3'b010) ? a_ext :
         (m_q[2:0] == 3'b011) ? a_ext << 1 :
         (m_q[2:0] == 3'b100) ? -(a_ext << 1) :
         (m_q[2:0] == 3'b101 || m_q[2:0] == 3'b110) ? -a_ext : '0;
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    a_d     = a_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d    = a_in;
        sign_d = fp_X[31] ^ fp_Y[31];
        m_d    = {{(MW-MAN_W-1){1'b0}}, b_in, 1'b0};
        acc_d  = '0;
        cnt_d  = '0;
`ifdef FP_MUL_BOOTH_ZERO_SKIP_EN
        state_d = (x_sub || y_sub) ? DONE : CALC;
`else
        state_d = CALC;
`endif
      end
      CALC: begin
        acc_d   = acc_q + (pp << {cnt_q, 1'b0});
        m_d     = m_q >> 2;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? DONE : CALC;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      a_q     <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      a_q     <= a_d;
      sign_q  <= sign_d;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign busy       = state_q == CALC;
  assign out_valid  = state_q == DONE;
  assign sign_Z     = sign_q;
  // partial sums stay hidden; only the finished product reaches the output
  assign frc_Z_full = out_valid ? acc_q[2*MAN_W-1:0] : '0;
endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// tb_fp_mul_booth_seq: directed table plus backpressure, mid-CALC reset and random-normal checks.
module tb_fp_mul_booth_seq;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] fp_X = 0, fp_Y = 0;
  logic        in_ready, out_valid, sign_Z, busy;
  logic [47:0] frc_Z_full;
  int checks = 0, errors = 0;
`ifdef FP_MUL_BOOTH_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 14;
`endif
  fp_mul_booth_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .out_valid(out_valid), .out_ready(out_ready),
    .frc_Z_full(frc_Z_full), .sign_Z(sign_Z), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] x, y;
    logic [47:0] frc;
    logic        sgn;
    int          lat;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic accept_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = 1; fp_X = x; fp_Y = y; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; fp_X = $urandom; fp_Y = $urandom;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask
  task automatic release_result();
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
  endtask
  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     output logic [47:0] p, output logic s, output int lat);
    accept_op(x, y);
    wait_valid(lat);
    p = frc_Z_full; s = sign_Z;
    release_result();
  endtask
  initial begin
    logic [47:0] p;
    logic        s;
    int          lat;
    logic [31:0] x, y;
    logic [63:0] ea, eb;
    tbl[0] = '{32'h3F800000, 32'h3F800000, 48'h400000000000, 1'b0, 14};
    tbl[1] = '{32'h3FC00000, 32'hBFC00000, 48'h900000000000, 1'b1, 14};
    tbl[2] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 48'hFFFFFE000001, 1'b0, 14};
    tbl[3] = '{32'h00000001, 32'h3F800000, 48'h0, 1'b0, ZLAT};
    tbl[4] = '{32'hC0000000, 32'h80400000, 48'h0, 1'b0, ZLAT};
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frc", frc_Z_full, 0);
    @(negedge clk); rst_n = 1;
    #1 chk("reset_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      run(tbl[i].x, tbl[i].y, p, s, lat);
      chk($sformatf("vec%0d_frc", i), p, tbl[i].frc);
      chk($sformatf("vec%0d_sign", i), s, tbl[i].sgn);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end
    for (int i = 0; i < 6; i++) begin
      x = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      y = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      ea = {40'd1, x[22:0]}; eb = {40'd1, y[22:0]};
      run(x, y, p, s, lat);
      chk($sformatf("rand%0d_frc", i), p, ea * eb);
      chk($sformatf("rand%0d_sign", i), s, x[31] ^ y[31]);
      chk($sformatf("rand%0d_msb", i), p[47:46] != 0, 1);
    end
    // backpressure with a competing request held on the input
    accept_op(32'h3FC00000, 32'hBFC00000);
    #0 chk("bp_busy", busy, 1);
    wait_valid(lat);
    chk("bp_lat", lat, 14);
    @(negedge clk); in_valid = 1; fp_X = 32'h3F800000; fp_Y = 32'h3F800000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_frc", c), frc_Z_full, 48'h900000000000);
      chk($sformatf("bp%0d_sign", c), sign_Z, 1);
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
    end
    @(negedge clk); in_valid = 0; out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    // reset during CALC discards the partial product
    accept_op(32'h3FFFFFFF, 32'h3FFFFFFF);
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_frc", frc_Z_full, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1;
    run(32'h3F800000, 32'h3F800000, p, s, lat);
    chk("post_rst_frc", p, 48'h400000000000);
    chk("post_rst_lat", lat, 14);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
